// File: rtl/tx_packet.sv
// tx_packet -- serial framer for one 8-byte packet.
//
// Frame: 0x02, payload[7:0], payload[15:8], ... payload[47:40], 0x03.
// Each byte is sent 8N1 (start 0, 8 data bits LSB first, stop 1), and each bit
// lasts CLKS_PER_BIT clocks. GAP_BITS idle-high bit periods separate
// consecutive bytes. There is no gap after the final byte.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (2..4095)
//   GAP_BITS     : idle bit periods between bytes (0..15)
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous reset, active low
//   tx_start : frame request, accepted only while tx_busy is low
//   payload  : 48-bit frame body, captured on the accept edge
//   data_out : registered serial line, idle high
//   tx_busy  : high from the cycle after acceptance until frame end
//   tx_done  : one-cycle pulse at frame end
module tx_packet #(
  parameter int CLKS_PER_BIT = 42,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [47:0] payload,
  output logic        data_out,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int GAP_LEN = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // With GAP_BITS=0 the GAP state is never entered, so this value is unused.
  localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t             state, state_nxt;
  logic [BAUD_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [2:0]         byte_idx, byte_idx_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [47:0]        payload_q, payload_q_nxt;
  logic               data_out_nxt, tx_busy_nxt, tx_done_nxt;
  logic [7:0]         cur_byte;

  // Byte k of the frame: header, six payload bytes, trailer.
  function automatic logic [7:0] frame_byte(input logic [47:0] p, input logic [2:0] idx);
    int i;
    if (idx == 3'd0)      return 8'h02;
    else if (idx == 3'd7) return 8'h03;
    i = int'(idx) - 1;
    return p[8*i +: 8];
  endfunction

  always_comb begin
    state_nxt     = state;
    baud_cnt_nxt  = baud_cnt;
    bit_idx_nxt   = bit_idx;
    byte_idx_nxt  = byte_idx;
    gap_cnt_nxt   = gap_cnt;
    payload_q_nxt = payload_q;
    data_out_nxt  = data_out;
    tx_busy_nxt   = tx_busy;
    tx_done_nxt   = 1'b0;
    cur_byte      = frame_byte(payload_q, byte_idx);

    case (state)
      IDLE: begin
        data_out_nxt = 1'b1;
        if (tx_start) begin
          // Line drops on the accept edge itself: the start bit of byte0.
          state_nxt     = START;
          baud_cnt_nxt  = '0;
          bit_idx_nxt   = '0;
          byte_idx_nxt  = '0;
          gap_cnt_nxt   = '0;
          payload_q_nxt = payload;
          data_out_nxt  = 1'b0;
          tx_busy_nxt   = 1'b1;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
          data_out_nxt = cur_byte[0];
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt    = STOP;
            data_out_nxt = 1'b1;
          end else begin
            bit_idx_nxt  = bit_idx + 3'd1;
            data_out_nxt = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          if (byte_idx == 3'd7) begin
            state_nxt   = IDLE;
            tx_busy_nxt = 1'b0;
            tx_done_nxt = 1'b1;
          end else if (GAP_BITS > 0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
          end else begin
            state_nxt    = START;
            byte_idx_nxt = byte_idx + 3'd1;
            data_out_nxt = 1'b0;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt  = '0;
          state_nxt    = START;
          byte_idx_nxt = byte_idx + 3'd1;
          data_out_nxt = 1'b0;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        data_out_nxt = 1'b1;
        tx_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      payload_q <= '0;
      data_out  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      byte_idx  <= byte_idx_nxt;
      gap_cnt   <= gap_cnt_nxt;
      payload_q <= payload_q_nxt;
      data_out  <= data_out_nxt;
      tx_busy   <= tx_busy_nxt;
      tx_done   <= tx_done_nxt;
    end
  end

endmodule

// File: tb/tb_tx_packet.sv
// Testbench for tx_packet: a default-parameter instance (42 clocks/bit,
// 1 gap bit) and a fast instance (4 clocks/bit, no gap). A frame reference
// computes the expected line level for every cycle from the frame rules,
// and a UART-style decoder recovers the bytes from the captured line.
module tb_tx_packet;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, start_v;
  logic [47:0] payload_v;
  int          sel;
  logic        start0, start1;
  logic        data0, busy0, done0, data1, busy1, done1;
  logic        line, busy, done;

  assign start0 = start_v && (sel == 0);
  assign start1 = start_v && (sel == 1);
  assign line   = (sel == 0) ? data0 : data1;
  assign busy   = (sel == 0) ? busy0 : busy1;
  assign done   = (sel == 0) ? done0 : done1;

  tx_packet #(.CLKS_PER_BIT(42), .GAP_BITS(1)) u_def (
    .clk(clk), .rst(rst0), .tx_start(start0), .payload(payload_v),
    .data_out(data0), .tx_busy(busy0), .tx_done(done0));

  tx_packet #(.CLKS_PER_BIT(4), .GAP_BITS(0)) u_fast (
    .clk(clk), .rst(rst1), .tx_start(start1), .payload(payload_v),
    .data_out(data1), .tx_busy(busy1), .tx_done(done1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [47:0] p, input int i);
    if (i == 0) return 8'h02;
    if (i == 7) return 8'h03;
    return p[8*(i-1) +: 8];
  endfunction

  // Expected line level k cycles after the accept edge (k < frame length).
  function automatic logic exp_level(input int k, input int c, input int g, input logic [47:0] p);
    int per, b, n;
    logic [7:0] by;
    per = (10 + g) * c;
    b   = k / per;
    n   = (k % per) / c;
    if (n == 0) return 1'b0;
    if (n <= 8) begin
      by = exp_byte(p, b);
      return by[n-1];
    end
    return 1'b1;
  endfunction

  // mode 0: single request pulse; 1: extra requests and payload churn during
  // the frame; 2: request held high, returns in the tx_done cycle still high.
  task automatic run_frame(input logic [47:0] p, input int mode, input string tag);
    int c, g, len, done_at, wave_err, busy_err, pos;
    logic s[$];
    logic [7:0] by;
    logic [8:0] got;
    c = (sel == 1) ? 4 : 42;
    g = (sel == 1) ? 0 : 1;
    len = (80 + 7 * g) * c;
    done_at = -1;
    wave_err = 0;
    busy_err = 0;
    payload_v = p;
    start_v = 1'b1;
    @(posedge clk); #1;
    s.push_back(line);
    if (busy !== 1'b1) busy_err++;
    start_v = (mode == 2);
    for (int k = 1; k <= len + 5; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      s.push_back(line);
      if (busy !== 1'b1) busy_err++;
      if (mode == 1) begin
        start_v = (k % 100 == 0);
        payload_v = {16'($urandom), $urandom};
      end
    end
    if (mode != 2) start_v = 1'b0;
    chk({tag, "_done_at"}, 64'(done_at), 64'(len));
    if (done_at == len) begin
      chk({tag, "_end_line"}, 64'(line), 64'(1));
      chk({tag, "_end_busy"}, 64'(busy), 64'(0));
    end
    for (int k = 0; k < s.size(); k++)
      if (s[k] !== exp_level(k, c, g, p)) wave_err++;
    if (s.size() != len) wave_err++;
    chk({tag, "_wave"}, 64'(wave_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy_err), 64'(0));
    pos = 0;
    for (int i = 0; i < 8; i++) begin
      while (pos < s.size() && s[pos] !== 1'b0) pos++;
      if (pos + 10 * c > s.size()) begin
        got = 9'h1ff;
      end else begin
        for (int j = 0; j < 8; j++) by[j] = s[pos + c * (j + 1) + c / 2];
        got = {~s[pos + 9 * c + c / 2], by};
        pos = pos + 10 * c;
      end
      chk($sformatf("%s_byte%0d", tag, i), 64'(got), 64'({1'b0, exp_byte(p, i)}));
    end
    if (mode != 2 && done_at == len) begin
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    int n_done, n_low, n_busy;
    sel = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    start_v = 1'b1;
    payload_v = {16'($urandom), $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line0", 64'(data0), 64'(1));
    chk("rst_busy0", 64'(busy0), 64'(0));
    chk("rst_done0", 64'(done0), 64'(0));
    chk("rst_line1", 64'(data1), 64'(1));
    chk("rst_busy1", 64'(busy1), 64'(0));
    chk("rst_done1", 64'(done1), 64'(0));
    rst0 = 1'b1;
    rst1 = 1'b1;

    run_frame(48'h0123456789AB, 0, "basic");
    run_frame({16'($urandom), $urandom}, 1, "ignore");
    run_frame({16'($urandom), $urandom}, 2, "b2b_a");
    run_frame({16'($urandom), $urandom}, 0, "b2b_b");

    // Reset in the middle of a frame.
    payload_v = {16'($urandom), $urandom};
    start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy0), 64'(1));
    rst0 = 1'b0;
    @(posedge clk); #1;
    chk("abort_line", 64'(data0), 64'(1));
    chk("abort_busy", 64'(busy0), 64'(0));
    chk("abort_done", 64'(done0), 64'(0));
    rst0 = 1'b1;
    n_done = 0; n_low = 0; n_busy = 0;
    repeat (4000) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0) n_done++;
      if (data0 !== 1'b1) n_low++;
      if (busy0 !== 1'b0) n_busy++;
    end
    chk("after_abort_done", 64'(n_done), 64'(0));
    chk("after_abort_line", 64'(n_low), 64'(0));
    chk("after_abort_busy", 64'(n_busy), 64'(0));
    rst0 = 1'b0;
    start_v = 1'b1;
    n_low = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (data0 !== 1'b1 || busy0 !== 1'b0) n_low++;
    end
    chk("start_in_rst", 64'(n_low), 64'(0));
    rst0 = 1'b1;
    run_frame({16'($urandom), $urandom}, 0, "post_rst");

    chk("fast_idle_line", 64'(data1), 64'(1));
    chk("fast_idle_busy", 64'(busy1), 64'(0));
    sel = 1;
    for (int i = 0; i < 8; i++)
      run_frame({16'($urandom), $urandom}, (i == 7) ? 0 : int'($urandom_range(0, 2)),
                $sformatf("fast%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
